// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU
// selects, state encoding, instruction field positions and decode class.
package cpu_ctrl_pkg;

  // Instruction field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;
  localparam int C_MSB  = 18;
  localparam int C_LSB  = 0;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU selects
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Sequencer states
  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  // One-hot instruction class produced by the opcode decoder
  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_alu_r;
    logic is_addi;
    logic is_nop;
    logic is_halt;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// the IR contents flow up, every strobe and select flows down.
interface control_unit_if #(parameter int ALUW = 4);
  logic [31:0]     ir;
  logic            pco, pci, pc_inc, iri;
  logic            mari, mdri, mdro, mem_read, mem_write;
  logic            ryi, zi, zo;
  logic [ALUW-1:0] alu_op;
  logic            gra, grb, grc, rin, rout, baout, csigno;
  logic            run, illegal;

  // Handshake: none; strobes are level signals valid for the whole clock
  // in which the sequencer holds a given state, and ir must be stable from
  // T3 through the end of the instruction.
  modport master (
    input  ir,
    output pco, pci, pc_inc, iri, mari, mdri, mdro, mem_read, mem_write,
           ryi, zi, zo, alu_op, gra, grb, grc, rin, rout, baout, csigno,
           run, illegal
  );

  modport slave (
    output ir,
    input  pco, pci, pc_inc, iri, mari, mdri, mdro, mem_read, mem_write,
           ryi, zi, zo, alu_op, gra, grb, grc, rin, rout, baout, csigno,
           run, illegal
  );
endinterface

// File: rtl/control_unit_opcode_decoder.sv
// Maps the opcode field to a one-hot instruction class and the ALU select
// used in T4 of register-register instructions.
module opcode_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic [OPW-1:0]  opcode,
  output op_class_t       op_class,
  output logic [ALUW-1:0] alu_op
);

  // Pure combinational classification; anything unlisted is illegal
  always_comb begin
    op_class = '0;
    alu_op   = ALUW'(ALU_ADD);
    case (opcode)
      OP_LD:   op_class.is_load  = 1'b1;
      OP_ST:   op_class.is_store = 1'b1;
      OP_ADD:  op_class.is_alu_r = 1'b1;
      OP_SUB:  begin op_class.is_alu_r = 1'b1; alu_op = ALUW'(ALU_SUB); end
      OP_AND:  begin op_class.is_alu_r = 1'b1; alu_op = ALUW'(ALU_AND); end
      OP_OR:   begin op_class.is_alu_r = 1'b1; alu_op = ALUW'(ALU_OR);  end
      OP_ADDI: op_class.is_addi  = 1'b1;
      OP_NOP:  op_class.is_nop   = 1'b1;
      OP_HALT: op_class.is_halt  = 1'b1;
      default: op_class.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: one micro-step per clock, Moore outputs
// decoded from the state register and the IR opcode.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master cu,
  output logic [3:0]     state
);

  logic [3:0]      state_next;
  op_class_t       cls;
  logic [ALUW-1:0] dec_alu_op;
  logic            mem_ref;

  opcode_decoder #(.OPW(OPW), .ALUW(ALUW)) u_dec (
    .opcode   (cu.ir[OP_LSB +: OPW]),
    .op_class (cls),
    .alu_op   (dec_alu_op)
  );

  assign mem_ref = cls.is_load | cls.is_store;

  // State register; clear drops straight to RESET so no partial write completes
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_RESET;
    else        state <= state_next;
  end

  // Sequencing: instruction length is decided in T3 and T5
  always_comb begin
    state_next = S_RESET;
    case (state)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3:    state_next = cls.is_halt ? S_HALT :
                            (cls.is_nop | cls.is_illegal) ? S_T0 : S_T4;
      S_T4:    state_next = S_T5;
      S_T5:    state_next = mem_ref ? S_T6 : S_T0;
      S_T6:    state_next = S_T7;
      S_T7:    state_next = S_T0;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end

  // Strobe decode; every strobe defaults low and alu_op defaults to ADD
  always_comb begin
    cu.pco = 1'b0; cu.pci = 1'b0; cu.pc_inc = 1'b0; cu.iri = 1'b0;
    cu.mari = 1'b0; cu.mdri = 1'b0; cu.mdro = 1'b0;
    cu.mem_read = 1'b0; cu.mem_write = 1'b0;
    cu.ryi = 1'b0; cu.zi = 1'b0; cu.zo = 1'b0;
    cu.alu_op = ALUW'(ALU_ADD);
    cu.gra = 1'b0; cu.grb = 1'b0; cu.grc = 1'b0;
    cu.rin = 1'b0; cu.rout = 1'b0; cu.baout = 1'b0; cu.csigno = 1'b0;
    cu.illegal = 1'b0;
    cu.run = (state >= S_T0) && (state <= S_T7);
    case (state)
      S_T0: begin cu.pco = 1'b1; cu.mari = 1'b1; cu.pc_inc = 1'b1; end
      S_T1: begin cu.mem_read = 1'b1; cu.mdri = 1'b1; end
      S_T2: begin cu.mdro = 1'b1; cu.iri = 1'b1; end
      S_T3: begin
        if (mem_ref) begin
          cu.grb = 1'b1; cu.baout = 1'b1; cu.ryi = 1'b1;
        end else if (cls.is_alu_r | cls.is_addi) begin
          cu.grb = 1'b1; cu.rout = 1'b1; cu.ryi = 1'b1;
        end
        cu.illegal = cls.is_illegal;
      end
      S_T4: begin
        cu.zi = 1'b1;
        if (cls.is_alu_r) begin
          cu.grc = 1'b1; cu.rout = 1'b1; cu.alu_op = dec_alu_op;
        end else begin
          cu.csigno = 1'b1;
        end
      end
      S_T5: begin
        cu.zo = 1'b1;
        if (mem_ref) cu.mari = 1'b1;
        else begin cu.gra = 1'b1; cu.rin = 1'b1; end
      end
      S_T6: begin
        cu.mdri = 1'b1;
        if (cls.is_load) cu.mem_read = 1'b1;
        else begin cu.gra = 1'b1; cu.rout = 1'b1; end
      end
      S_T7: begin
        if (cls.is_load) begin
          cu.mdro = 1'b1; cu.gra = 1'b1; cu.rin = 1'b1;
        end else begin
          cu.mem_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: expected per-cycle strobe vectors are queued when
// an instruction is driven and popped at each falling edge.
module tb_control_unit;

  logic       clock;
  logic       clear;
  logic [3:0] state;

  control_unit_if cu_bus ();

  control_unit dut (
    .clock (clock),
    .clear (clear),
    .cu    (cu_bus),
    .state (state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bit positions of the packed strobe vector (alu_op in [3:0])
  localparam int B_PCO = 4, B_PCI = 5, B_PCINC = 6, B_IRI = 7, B_MARI = 8;
  localparam int B_MDRI = 9, B_MDRO = 10, B_MRD = 11, B_MWR = 12, B_RYI = 13;
  localparam int B_ZI = 14, B_ZO = 15, B_GRA = 16, B_GRB = 17, B_GRC = 18;
  localparam int B_RIN = 19, B_ROUT = 20, B_BAOUT = 21, B_CSIGNO = 22;
  localparam int B_RUN = 23, B_ILL = 24;
  localparam int W = 29;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [24:0] obs_vec();
    return {cu_bus.illegal, cu_bus.run, cu_bus.csigno, cu_bus.baout, cu_bus.rout,
            cu_bus.rin, cu_bus.grc, cu_bus.grb, cu_bus.gra, cu_bus.zo, cu_bus.zi,
            cu_bus.ryi, cu_bus.mem_write, cu_bus.mem_read, cu_bus.mdro, cu_bus.mdri,
            cu_bus.mari, cu_bus.iri, cu_bus.pc_inc, cu_bus.pci, cu_bus.pco,
            cu_bus.alu_op};
  endfunction

  function automatic int len_of(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00010: return 8;
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100: return 6;
      default: return 4;
    endcase
  endfunction

  // Reference micro-step table written from the instruction descriptions
  function automatic logic [24:0] exp_vec(input logic [4:0] op, input int k);
    logic [24:0] v;
    logic ldst, alur, addi, ld, legal;
    ld    = (op == 5'b00000);
    ldst  = ld || (op == 5'b00010);
    alur  = (op == 5'b00011) || (op == 5'b00100) || (op == 5'b00101) || (op == 5'b00110);
    addi  = (op == 5'b01100);
    legal = ldst || alur || addi || (op == 5'b11010) || (op == 5'b11011);
    v = '0;
    v[B_RUN] = 1'b1;
    case (k)
      0: begin v[B_PCO] = 1; v[B_MARI] = 1; v[B_PCINC] = 1; end
      1: begin v[B_MRD] = 1; v[B_MDRI] = 1; end
      2: begin v[B_MDRO] = 1; v[B_IRI] = 1; end
      3: begin
        if (ldst) begin v[B_GRB] = 1; v[B_BAOUT] = 1; v[B_RYI] = 1; end
        if (alur || addi) begin v[B_GRB] = 1; v[B_ROUT] = 1; v[B_RYI] = 1; end
        if (!legal) v[B_ILL] = 1;
      end
      4: begin
        v[B_ZI] = 1;
        if (alur) begin
          v[B_GRC] = 1; v[B_ROUT] = 1;
          if (op == 5'b00100) v[3:0] = 4'b0001;
          if (op == 5'b00101) v[3:0] = 4'b0010;
          if (op == 5'b00110) v[3:0] = 4'b0011;
        end else v[B_CSIGNO] = 1;
      end
      5: begin
        v[B_ZO] = 1;
        if (ldst) v[B_MARI] = 1;
        else begin v[B_GRA] = 1; v[B_RIN] = 1; end
      end
      6: begin
        v[B_MDRI] = 1;
        if (ld) v[B_MRD] = 1;
        else begin v[B_GRA] = 1; v[B_ROUT] = 1; end
      end
      7: begin
        if (ld) begin v[B_MDRO] = 1; v[B_GRA] = 1; v[B_RIN] = 1; end
        else v[B_MWR] = 1;
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic compare_cycle(input string tag);
    logic [W-1:0] e;
    logic [24:0]  o;
    o = obs_vec();
    e = exp_q.pop_front();
    check(tag, 32'({state, o}), 32'(e));
    check({tag, "_bus"}, 32'($countones({o[B_PCO], o[B_MDRO], o[B_ZO], o[B_ROUT],
                                          o[B_BAOUT], o[B_CSIGNO]}) <= 1), 32'd1);
  endtask

  // Driver: queue the instruction's whole expected sequence, then follow it.
  // ir is written in T0 so the previous instruction's sequencing is undisturbed.
  task automatic run_instr(input logic [31:0] ir_val, input string name, input int abort_at);
    int n;
    n = len_of(ir_val[31:27]);
    for (int k = 0; k < n; k++)
      exp_q.push_back({4'(k + 1), exp_vec(ir_val[31:27], k)});
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      compare_cycle($sformatf("%s_t%0d", name, k));
      if (k == 0) cu_bus.ir = ir_val;
      if (k == abort_at) begin
        clear = 1'b0;
        #1;
        check({name, "_async_clr"}, 32'({state, obs_vec()}), 32'd0);
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic hold_reset(input string name);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('0);
      @(negedge clock);
      compare_cycle($sformatf("%s_rst%0d", name, i));
    end
    clear = 1'b1;
  endtask

  logic [4:0] op_tab [11];

  initial begin
    op_tab = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
               5'b01100, 5'b11010, 5'b11111, 5'b00001, 5'b10101};
    cu_bus.ir = 32'h0;
    clear = 1'b0;
    #1;
    check("reset_async", 32'({state, obs_vec()}), 32'd0);
    hold_reset("init");

    run_instr(32'h1080_0005, "st", -1);
    run_instr(32'h0080_0010, "ld", -1);
    run_instr(32'h1889_8000, "add", -1);
    run_instr({5'b00100, 27'h0898000}, "sub", -1);
    run_instr({5'b00101, 27'h0898000}, "and", -1);
    run_instr({5'b00110, 27'h0898000}, "or", -1);
    run_instr({5'b01100, 27'h0880007}, "addi", -1);
    run_instr({5'b11010, 27'h0}, "nop", -1);
    run_instr({5'b11111, 27'h0}, "ill", -1);

    for (int i = 0; i < 12; i++) begin
      logic [4:0] op;
      op = op_tab[$urandom_range(0, 10)];
      run_instr({op, 27'($urandom)}, $sformatf("rnd%0d_op%b", i, op), -1);
    end

    // Halt: terminal, all strobes low, run low
    run_instr({5'b11011, 27'h0}, "halt", -1);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back({4'd9, 25'd0});
      @(negedge clock);
      compare_cycle($sformatf("halted%0d", i));
    end
    hold_reset("post_halt");

    // Reset mid-store in T6: no mem_write may follow
    run_instr(32'h1080_0005, "st_abort", 6);
    hold_reset("abort");
    run_instr(32'h1080_0005, "st_restart", -1);
    run_instr({5'b11010, 27'h0}, "nop_end", -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the RISC CPU. It sits directly upstream of `datapath` and drives every datapath control strobe, register-select, memory-strobe and ALU-select signal, one micro-step per clock, so the datapath runs real fetch/decode/execute sequences instead of bench-driven ones. It reads only the instruction word held in the datapath IR.

## Interface
Parameters:
- `OPW`, 5, opcode width; opcode is `ir[31:27]`.
- `ALUW`, 4, width of `alu_op`.

Ports:
- `clock`  in  1  single system clock; all state changes on rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `ir`  in  32  instruction register contents from the datapath.
- `pco`, `pci`, `pc_inc`  out  1 each  PC→bus; bus→PC; PC←PC+1.
- `iri`  out  1  bus→IR.
- `mari`, `mdri`, `mdro`  out  1 each  bus→MAR; MDR load; MDR→bus.
- `mem_read`, `mem_write`  out  1 each  RAM read (also MDR mux select: 1 = RAM, 0 = bus); RAM write.
- `ryi`, `zi`, `zo`  out  1 each  bus→Y; ALU→Z; Z→bus.
- `alu_op`  out  ALUW  ADD 0000, SUB 0001, AND 0010, OR 0011.
- `gra`, `grb`, `grc`, `rin`, `rout`, `baout`  out  1 each  register-file select and enables.
- `csigno`  out  1  sign-extended C field→bus.
- `run`  out  1  high while executing, low in HALT.
- `illegal`  out  1  one-cycle pulse when an undefined opcode is decoded.

## Operation
- States: RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT. Each state lasts one clock.
- Opcodes: ld 00000, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, nop 11010, halt 11011. Any other opcode is illegal and executes as nop with `illegal`=1 in T3.
- Fetch:
  - T0: `pco` `mari` `pc_inc`.
  - T1: `mem_read` `mdri`.
  - T2: `mdro` `iri`.
- ld ra,C(rb):
  - T3: `grb` `baout` `ryi`.
  - T4: `csigno` ADD `zi`.
  - T5: `zo` `mari`.
  - T6: `mem_read` `mdri`.
  - T7: `mdro` `gra` `rin`, then T0.
- st ra,C(rb):
  - T3–T5 as ld.
  - T6: `gra` `rout` `mdri` (`mem_read`=0).
  - T7: `mem_write`, then T0.
- add/sub/and/or ra,rb,rc:
  - T3: `grb` `rout` `ryi`.
  - T4: `grc` `rout` op `zi`.
  - T5: `zo` `gra` `rin`, then T0.
- addi ra,rb,C:
  - T3: `grb` `rout` `ryi`.
  - T4: `csigno` ADD `zi`.
  - T5: `zo` `gra` `rin`, then T0.
- nop / illegal: T3 then T0.
- halt: T3 then HALT. HALT is terminal until `clear`; all strobes are 0 and `run`=0.
- Every strobe not listed for a state is 0. `alu_op` defaults to ADD.
- At most one bus driver is active per state (`pco`, `mdro`, `zo`, `rout`, `baout`, `csigno` are mutually exclusive).

## Timing
- `clear` low: state←RESET immediately, regardless of clock. All outputs are 0, `run`=0, `alu_op`=0000. This applies mid-instruction as well; no partial write is completed.
- First rising edge with `clear` high: RESET→T0, and `run`=1 from then on.
- Outputs are Moore: combinational decode of the state register and `ir[31:27]`. `ir` is sampled only in T3–T7, when it is stable because `iri` fires only in T2.
- Instruction lengths in clocks, including fetch: nop/illegal 4; add/sub/and/or/addi 6; ld/st 8.
- `mem_write` is high for exactly one clock, in T7 of st. `mem_read` is high in T1, and in T6 of ld only.
- `pc_inc` is high only in T0, so PC advances exactly once per instruction.

## Structure
- Shared package `cpu_ctrl_pkg`: opcode constants, `alu_op` constants, state encoding (4-bit), instruction field positions.
- Sub-module `opcode_decoder`: combinational mapping from `ir[31:27]` to one-hot class (LOAD, STORE, ALU_R, ADDI, NOP, HALT, ILLEGAL) plus `alu_op`. `control_unit` holds the state register and the strobe decode.

## Test plan
- Reset: hold `clear`=0 for 3 clocks → all outputs 0. Release → T0 with `pco`=`mari`=`pc_inc`=1 on the next cycle, and `run`=1.
- st: `ir`=0x1080_0005 → T0–T7 in 8 clocks. `csigno`&`zi` in T4; `gra`&`rout`&`mdri` with `mem_read`=0 in T6; `mem_write` for exactly 1 clock in T7; back to T0.
- ld / add: `ir`=0x0080_0010 → `mdro`&`gra`&`rin` in T7. `ir`=0x1889_8000 (add) → `grc`&`rout`, `alu_op`=0000, `zi` in T4; T0 after 6 clocks.
- sub / and / or / addi: same 6-clock shape. `alu_op` = 0001 / 0010 / 0011 / 0000 in T4; addi drives `csigno` (not `grc`) in T4.
- Special opcodes: opcode 11111 → `illegal` for one cycle in T3, then T0. halt 11011 → HALT, `run`=0, strobes 0 for 20 clocks.
- Reset mid-st: drop `clear` during T6 → outputs 0 asynchronously, no `mem_write` pulse. After release, execution restarts at T0.
